// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: state enum, reset instruction, IR field positions.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_BUSY = 1'b1
    } fetch_state_e;

    localparam word_t NOP_INSN = 32'h0000_0013;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC mux/adder. With FETCH_MISALIGN_TRAP_EN a misaligned
// jump target is rejected and latched in a sticky error flag; otherwise low bits are cleared.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  pc_write_i,
    input  logic  pc_sel_i,
    input  word_t pc_target_i,
    output word_t pc_o,
    output logic  misalign_err_o
);

    word_t pc_q, pc_d;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic err_q, err_d, bad_target;

    always_comb begin
        bad_target = pc_write_i && pc_sel_i && (pc_target_i[1:0] != 2'b00);
        err_d      = err_q | bad_target;
        pc_d       = pc_q;
        if (pc_write_i && !bad_target)
            pc_d = pc_sel_i ? pc_target_i : pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign misalign_err_o = err_q;
`else
    always_comb begin
        pc_d = pc_q;
        if (pc_write_i)
            pc_d = pc_sel_i ? (pc_target_i & 32'hFFFF_FFFC) : pc_q + 32'd4;
    end

    assign misalign_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I multi-cycle fetch stage: PC, IR, and req/ack handshake to instruction memory.
// Optional misaligned-target trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_Write,
    input  logic        IR_Write,
    input  logic        pc_sel,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        fetch_busy,
    output logic        ir_valid,
    output logic        misalign_err
);

    fetch_state_e state_q, state_d;
    word_t        ir_q, ir_d, addr_q, addr_d;
    logic         req_q, req_d, vld_q, vld_d;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write_i    (PC_Write),
        .pc_sel_i      (pc_sel),
        .pc_target_i   (pc_target),
        .pc_o          (pc),
        .misalign_err_o(misalign_err)
    );

    // The fetch latches the pre-update PC, so a same-edge PC_Write never races it.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        req_d   = req_q;
        vld_d   = 1'b0;
        case (state_q)
            F_IDLE: if (IR_Write && !misalign_err) begin
                addr_d  = pc;
                req_d   = 1'b1;
                state_d = F_BUSY;
            end
            F_BUSY: if (imem_ack) begin
                ir_d    = imem_rdata;
                vld_d   = 1'b1;
                req_d   = 1'b0;
                state_d = F_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= F_IDLE;
            ir_q    <= NOP_INSN;
            addr_q  <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign ir         = ir_q;
    assign ir_valid   = vld_q;
    assign fetch_busy = (state_q == F_BUSY);
    assign opcode     = ir_q[OPC_LSB +: 7];
    assign rd         = ir_q[RD_LSB  +: 5];
    assign funct3     = ir_q[F3_LSB  +: 3];
    assign rs1        = ir_q[RS1_LSB +: 5];
    assign rs2        = ir_q[RS2_LSB +: 5];
    assign funct7     = ir_q[F7_LSB  +: 7];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a transaction-level reference model.
module tb_fetch_unit;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        PC_Write = 0, IR_Write = 0, pc_sel = 0, imem_ack = 0;
    logic [31:0] pc_target = 0, imem_rdata = 0;
    logic        imem_req, fetch_busy, ir_valid, misalign_err;
    logic [31:0] imem_addr, pc, ir;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;

    int checks = 0, errors = 0;

    // reference model state
    logic [31:0] m_pc, m_ir, m_addr;
    bit          m_busy, m_valid, m_err;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .PC_Write(PC_Write), .IR_Write(IR_Write),
        .pc_sel(pc_sel), .pc_target(pc_target), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .pc(pc), .ir(ir), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .fetch_busy(fetch_busy),
        .ir_valid(ir_valid), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0000_0013; m_addr = 32'h0;
        m_busy = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc,                 m_pc);
        chk({tag, ".ir"},    ir,                 m_ir);
        chk({tag, ".req"},   {31'b0, imem_req},  {31'b0, m_busy});
        chk({tag, ".busy"},  {31'b0, fetch_busy}, {31'b0, m_busy});
        chk({tag, ".addr"},  imem_addr,          m_addr);
        chk({tag, ".valid"}, {31'b0, ir_valid},  {31'b0, m_valid});
        chk({tag, ".err"},   {31'b0, misalign_err}, {31'b0, m_err});
        chk({tag, ".fields"},
            {funct7, rs2, rs1, funct3, rd, opcode},
            {m_ir[31:25], m_ir[24:20], m_ir[19:15], m_ir[14:12], m_ir[11:7], m_ir[6:0]});
    endtask

    // Advance one edge: predict from the inputs about to be sampled, then compare.
    task automatic tick(input string tag);
        logic [31:0] tgt;
        tgt = pc_target;
        m_valid = 0;
        if (m_busy) begin
            if (imem_ack) begin m_ir = imem_rdata; m_valid = 1; m_busy = 0; end
        end else if (IR_Write && !m_err) begin
            m_busy = 1; m_addr = m_pc;
        end
        if (PC_Write) begin
            if (!pc_sel)                          m_pc = m_pc + 32'd4;
            else if (TRAP && tgt[1:0] != 2'b00)   m_err = 1;
            else                                  m_pc = tgt & 32'hFFFF_FFFC;
        end
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic jump(input logic [31:0] t);
        PC_Write = 1; pc_sel = 1; pc_target = t;
        tick("jump");
        PC_Write = 0; pc_sel = 0;
    endtask

    initial begin
        logic [31:0] a0;
        model_reset();
        #12 rst_n = 1;
        #1;
        check_all("reset");
        chk("reset_ir", ir, 32'h0000_0013);

        // zero-wait fetch
        IR_Write = 1; imem_ack = 1; imem_rdata = 32'h0050_0093;
        tick("zw1");
        IR_Write = 0;
        chk("zw_req", {31'b0, imem_req}, 32'd1);
        tick("zw2");
        chk("zw_ir", ir, 32'h0050_0093);
        chk("zw_opc", {25'b0, opcode}, 32'h13);
        chk("zw_rd", {27'b0, rd}, 32'd1);
        chk("zw_vld", {31'b0, ir_valid}, 32'd1);
        imem_ack = 0;
        tick("zw3");
        chk("zw_vld_off", {31'b0, ir_valid}, 32'd0);

        // wait states with extra IR_Write pulses ignored
        jump(32'h40);
        IR_Write = 1;
        tick("ws_start");
        a0 = imem_addr;
        chk("ws_addr", a0, 32'h40);
        for (int i = 0; i < 3; i++) begin
            IR_Write = i[0];
            imem_rdata = $urandom;
            tick("ws_wait");
            chk("ws_addr_hold", imem_addr, a0);
            chk("ws_no_vld", {31'b0, ir_valid}, 32'd0);
        end
        IR_Write = 0; imem_ack = 1; imem_rdata = 32'hDEAD_B0B3;
        tick("ws_ack");
        chk("ws_ir", ir, 32'hDEAD_B0B3);
        imem_ack = 0;
        tick("ws_post");
        chk("ws_busy_off", {31'b0, fetch_busy}, 32'd0);

        // simultaneous IR_Write + PC_Write
        jump(32'h10);
        IR_Write = 1; PC_Write = 1; pc_sel = 0;
        tick("sim");
        IR_Write = 0; PC_Write = 0;
        chk("sim_addr", imem_addr, 32'h10);
        chk("sim_pc", pc, 32'h14);
        imem_ack = 1; imem_rdata = $urandom;
        tick("sim_ack");
        imem_ack = 0;

        // wrap and jump
        jump(32'hFFFF_FFFC);
        PC_Write = 1; pc_sel = 0;
        tick("wrap");
        chk("wrap_pc", pc, 32'h0);
        jump(32'h200);
        chk("jump_pc", pc, 32'h200);

        // asynchronous reset mid-fetch
        IR_Write = 1;
        tick("rst_fetch");
        IR_Write = 0;
        chk("rst_req_before", {31'b0, imem_req}, 32'd1);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("rst_mid");
        chk("rst_req_drop", {31'b0, imem_req}, 32'd0);
        #2 rst_n = 1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            IR_Write   = ($urandom_range(3) == 0);
            PC_Write   = ($urandom_range(2) == 0);
            pc_sel     = $urandom_range(1);
            pc_target  = $urandom;
            if (TRAP) pc_target[1:0] = 2'b00;
            imem_ack   = ($urandom_range(2) == 0);
            imem_rdata = $urandom;
            tick("rand");
        end
        IR_Write = 0; PC_Write = 0; imem_ack = 1;
        tick("drain");
        imem_ack = 0;

        // misaligned jump target
        jump(32'h100);
        jump(32'h202);
        chk("mis_pc", pc, TRAP ? 32'h100 : 32'h200);
        chk("mis_err", {31'b0, misalign_err}, {31'b0, TRAP});
        IR_Write = 1;
        tick("mis_fetch");
        IR_Write = 0;
        chk("mis_fetch_req", {31'b0, imem_req}, {31'b0, !TRAP});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
